// File: rtl/wam_disp.sv
// Whack-a-mole display back end: 4-digit multiplexed 7-segment scan
// with per-frame score shadow, leading-zero blanking, dp flash and LED blink.
module wam_disp #(
    parameter int SCAN_DIV     = 17,
    parameter int BLINK_DIV    = 24,
    parameter int FLASH_FRAMES = 64
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [11:0] score,
    input  logic [7:0]  holes,
    input  logic        pause_flg,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [7:0]  led
);

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_P     = 7'b0001100;

    logic [SCAN_DIV-1:0]  presc_q, presc_d;
    logic [BLINK_DIV-1:0] blink_q;
    logic [1:0]           idx_q, idx_d;
    logic [11:0]          shadow_q, shadow_d;
    logic [7:0]           flash_q, flash_d;
    logic [3:0]           an_q, an_d;
    logic [6:0]           seg_q, seg_d;
    logic                 dp_q, dp_d;
    logic [7:0]           led_q;
    logic                 tick, frame;
    logic [11:0]          cur;

    function automatic logic [6:0] enc(input logic [3:0] n);
        case (n)
            4'd0:    enc = 7'b1000000;
            4'd1:    enc = 7'b1111001;
            4'd2:    enc = 7'b0100100;
            4'd3:    enc = 7'b0110000;
            4'd4:    enc = 7'b0011001;
            4'd5:    enc = 7'b0010010;
            4'd6:    enc = 7'b0000010;
            4'd7:    enc = 7'b1111000;
            4'd8:    enc = 7'b0000000;
            4'd9:    enc = 7'b0010000;
            default: enc = SEG_DASH;
        endcase
    endfunction

    assign tick  = (presc_q == '1);
    assign frame = tick && (idx_q == 2'd3);
    // Digit 0 of a new frame shows the score captured on that same edge.
    assign cur   = frame ? score : shadow_q;

    always_comb begin
        presc_d  = presc_q + SCAN_DIV'(1);
        idx_d    = idx_q;
        shadow_d = shadow_q;
        flash_d  = flash_q;
        an_d     = an_q;
        seg_d    = seg_q;
        dp_d     = dp_q;
        if (tick) begin
            idx_d = idx_q + 2'd1;
            if (frame) begin
                shadow_d = score;
                if (score != shadow_q)
                    flash_d = 8'(FLASH_FRAMES);
                else if (flash_q != 8'd0)
                    flash_d = flash_q - 8'd1;
            end
            an_d = ~(4'b0001 << idx_d);
            unique case (idx_d)
                2'd0: seg_d = enc(cur[3:0]);
                2'd1: seg_d = (cur[11:4] == 8'd0) ? SEG_BLANK : enc(cur[7:4]);
                2'd2: seg_d = (cur[11:8] == 4'd0) ? SEG_BLANK : enc(cur[11:8]);
                2'd3: seg_d = pause_flg ? SEG_P : SEG_BLANK;
            endcase
            dp_d = (flash_d == 8'd0);
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            presc_q  <= '0;
            blink_q  <= '0;
            idx_q    <= 2'd3;
            shadow_q <= 12'h000;
            flash_q  <= 8'd0;
            an_q     <= 4'b1111;
            seg_q    <= SEG_BLANK;
            dp_q     <= 1'b1;
            led_q    <= 8'h00;
        end else begin
            presc_q  <= presc_d;
            blink_q  <= blink_q + BLINK_DIV'(1);
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            flash_q  <= flash_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
            led_q    <= pause_flg ? (holes & {8{blink_q[BLINK_DIV-1]}}) : holes;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;
    assign led = led_q;

endmodule

// File: tb/tb_wam_disp.sv
// Directed bench for wam_disp with a fast scan: digit steps every 4 clk,
// blink toggles every 4 clk, dp flash lasts 2 frames.
module tb_wam_disp;

    logic        clk = 1'b0;
    logic        clr;
    logic [11:0] score;
    logic [7:0]  holes;
    logic        pause_flg;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [7:0]  led;

    int checks = 0;
    int errors = 0;
    int ncyc   = 0;

    localparam logic [6:0] BL = 7'h7F;
    localparam logic [6:0] D0 = 7'b1000000;
    localparam logic [6:0] D1 = 7'b1111001;
    localparam logic [6:0] D2 = 7'b0100100;
    localparam logic [6:0] D3 = 7'b0110000;
    localparam logic [6:0] D5 = 7'b0010010;
    localparam logic [6:0] D7 = 7'b1111000;
    localparam logic [6:0] DS = 7'b0111111;
    localparam logic [6:0] SP = 7'b0001100;

    wam_disp #(
        .SCAN_DIV(2),
        .BLINK_DIV(3),
        .FLASH_FRAMES(2)
    ) dut (
        .clk(clk),
        .clr(clr),
        .score(score),
        .holes(holes),
        .pause_flg(pause_flg),
        .an(an),
        .seg(seg),
        .dp(dp),
        .led(led)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            ncyc++;
        end
        #1;
    endtask

    // led after edge m reflects blink counter value m-1 (bit 2 of it).
    function automatic logic [7:0] exp_led();
        if (!pause_flg) return holes;
        return (((ncyc - 1) % 8) >= 4) ? holes : 8'h00;
    endfunction

    task automatic frame(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                         input logic [6:0] s2, input logic [6:0] s3, input logic d);
        logic [6:0] s [4];
        logic [3:0] a;
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
        for (int i = 0; i < 4; i++) begin
            step(4);
            a = ~(4'b0001 << i);
            chk($sformatf("%s.an%0d", tag, i), {4'h0, an}, {4'h0, a});
            chk($sformatf("%s.seg%0d", tag, i), {1'b0, seg}, {1'b0, s[i]});
            chk($sformatf("%s.dp%0d", tag, i), {7'h0, dp}, {7'h0, d});
            chk($sformatf("%s.led%0d", tag, i), led, exp_led());
        end
    endtask

    initial begin
        clr = 1'b1;
        score = 12'h305;
        holes = 8'h3C;
        pause_flg = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.an", {4'h0, an}, 8'h0F);
        chk("rst.seg", {1'b0, seg}, 8'h7F);
        chk("rst.dp", {7'h0, dp}, 8'h01);
        chk("rst.led", led, 8'h00);
        clr = 1'b0;
        ncyc = 0;

        frame("f1", D5, D0, D3, BL, 1'b0);
        frame("f2", D5, D0, D3, BL, 1'b0);

        step(4);
        chk("f3.seg0", {1'b0, seg}, {1'b0, D5});
        chk("f3.dp0", {7'h0, dp}, 8'h01);
        score = 12'h007;
        step(4);
        chk("f3.mid.an1", {4'h0, an}, 8'h0D);
        chk("f3.mid.seg1", {1'b0, seg}, {1'b0, D0});
        step(4);
        chk("f3.mid.seg2", {1'b0, seg}, {1'b0, D3});
        step(4);
        chk("f3.seg3", {1'b0, seg}, {1'b0, BL});

        frame("s007", D7, BL, BL, BL, 1'b0);
        score = 12'h000;
        frame("s000", D0, BL, BL, BL, 1'b0);
        score = 12'h012;
        frame("s012a", D2, D1, BL, BL, 1'b0);
        frame("s012b", D2, D1, BL, BL, 1'b0);
        frame("s012c", D2, D1, BL, BL, 1'b1);
        score = 12'h013;
        frame("fl1", D3, D1, BL, BL, 1'b0);
        frame("fl2", D3, D1, BL, BL, 1'b0);
        frame("fl3", D3, D1, BL, BL, 1'b1);

        holes = 8'hA5;
        pause_flg = 1'b1;
        frame("pause", D3, D1, BL, SP, 1'b1);
        for (int i = 0; i < 8; i++) begin
            step(1);
            chk($sformatf("blink%0d", i), led, exp_led());
        end
        pause_flg = 1'b0;
        step(1);
        chk("unpause.led", led, 8'hA5);
        step(7);

        score = 12'h0A0;
        frame("bad", D0, DS, BL, BL, 1'b0);

        step(12);
        chk("mid.an2", {4'h0, an}, 8'h0B);
        clr = 1'b1;
        #2;
        chk("mid.rst.an", {4'h0, an}, 8'h0F);
        chk("mid.rst.seg", {1'b0, seg}, 8'h7F);
        chk("mid.rst.dp", {7'h0, dp}, 8'h01);
        chk("mid.rst.led", led, 8'h00);
        step(2);
        clr = 1'b0;
        ncyc = 0;
        step(3);
        chk("rel.an.hold", {4'h0, an}, 8'h0F);
        step(1);
        chk("rel.an", {4'h0, an}, 8'h0E);
        chk("rel.seg", {1'b0, seg}, {1'b0, D0});
        chk("rel.dp", {7'h0, dp}, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
